approx_mul_err_acc: RTL and testbench

//  Downstream error-metric stage for the generated approximate multipliers. Each beat carries

---
 rtl/approx_mul_pkg.sv | 19 +
 rtl/approx_mul_err_acc_stage.sv | 79 +++++++
 rtl/approx_mul_err_acc.sv | 140 ++++++++++++++
 tb/tb_approx_mul_err_acc.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/approx_mul_pkg.sv
// Shared constants, FSM encoding and helpers for the approximate-multiplier error stage.
package approx_mul_pkg;

   localparam int unsigned DEFAULT_WIDTH        = 8;
   localparam int unsigned DEFAULT_SAMPLES_LOG2 = 4;

   typedef logic [1:0] err_state_t;

   localparam err_state_t ST_IDLE  = 2'd0;
   localparam err_state_t ST_RUN   = 2'd1;
   localparam err_state_t ST_DRAIN = 2'd2;
   localparam err_state_t ST_DONE  = 2'd3;

   // Magnitude of a two's complement value; callers sign-extend to 33 bits and keep the low bits.
   function automatic logic [31:0] abs_w(input logic [32:0] d);
      abs_w = d[32] ? 32'(-d) : d[31:0];
   endfunction

endpackage

// File: rtl/approx_mul_err_acc_stage.sv
// Two-stage pipeline: exact product, then signed and absolute error, with a valid shift-chain.
module approx_err_stage
   import approx_mul_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_a,
   input  logic [WIDTH-1:0]     in_b,
   input  logic [2*WIDTH-1:0]   in_approx,
   output logic                 pipe_busy,
   output logic                 out_valid,
   output logic [2*WIDTH:0]     out_d,
   output logic [2*WIDTH-1:0]   out_abs,
   output logic [WIDTH-1:0]     out_a,
   output logic [WIDTH-1:0]     out_b
);

   logic                 v1_q, v1_d, v2_q, v2_d;
   logic [2*WIDTH-1:0]   exact_q, exact_d, approx_q, approx_d;
   logic [WIDTH-1:0]     a1_q, a1_d, b1_q, b1_d, a2_q, a2_d, b2_q, b2_d;
   logic [2*WIDTH:0]     d_q, d_d;
   logic [2*WIDTH-1:0]   abs_q, abs_d;
   logic [31:0]          abs_full;
   logic                 unused_abs_hi;

   always_comb begin
      v1_d     = in_valid;
      exact_d  = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};
      approx_d = in_approx;
      a1_d     = in_a;
      b1_d     = in_b;

      v2_d     = v1_q;
      d_d      = {1'b0, exact_q} - {1'b0, approx_q};
      // |d| always fits in 2*WIDTH bits since both operands are unsigned 2*WIDTH values.
      abs_full      = abs_w(33'($signed(d_d)));
      abs_d         = abs_full[2*WIDTH-1:0];
      unused_abs_hi = ^abs_full[31:2*WIDTH];
      a2_d     = a1_q;
      b2_d     = b1_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         exact_q  <= '0;
         approx_q <= '0;
         a1_q     <= '0;
         b1_q     <= '0;
         d_q      <= '0;
         abs_q    <= '0;
         a2_q     <= '0;
         b2_q     <= '0;
      end else begin
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         exact_q  <= exact_d;
         approx_q <= approx_d;
         a1_q     <= a1_d;
         b1_q     <= b1_d;
         d_q      <= d_d;
         abs_q    <= abs_d;
         a2_q     <= a2_d;
         b2_q     <= b2_d;
      end
   end

   assign pipe_busy = v1_q | v2_q;
   assign out_valid = v2_q;
   assign out_d     = d_q;
   assign out_abs   = abs_q;
   assign out_a     = a2_q;
   assign out_b     = b2_q;

endmodule

// File: rtl/approx_mul_err_acc.sv
// Error-metric accumulator for approximate multipliers: window FSM, accept counter, statistics.
module approx_mul_err_acc
   import approx_mul_pkg::*;
#(
   parameter int unsigned WIDTH        = DEFAULT_WIDTH,
   parameter int unsigned SAMPLES_LOG2 = DEFAULT_SAMPLES_LOG2,
   localparam int unsigned ACC_W       = 2 * WIDTH + SAMPLES_LOG2
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [WIDTH-1:0]        in_a,
   input  logic [WIDTH-1:0]        in_b,
   input  logic [2*WIDTH-1:0]      in_approx,
   output logic                    busy,
   output logic                    done,
   output logic [SAMPLES_LOG2:0]   err_count,
   output logic [ACC_W-1:0]        sum_abs_err,
   output logic [ACC_W:0]          sum_err,
   output logic [2*WIDTH-1:0]      max_abs_err,
   output logic [WIDTH-1:0]        worst_a,
   output logic [WIDTH-1:0]        worst_b
);

   localparam logic [SAMPLES_LOG2:0] NBEATS    = {1'b1, {SAMPLES_LOG2{1'b0}}};
   localparam logic [SAMPLES_LOG2:0] LAST_BEAT = {1'b0, {SAMPLES_LOG2{1'b1}}};
   localparam logic [SAMPLES_LOG2:0] CNT_ONE   = {{SAMPLES_LOG2{1'b0}}, 1'b1};

   err_state_t             state_q, state_d;
   logic [SAMPLES_LOG2:0]  cnt_q, cnt_d;
   logic [SAMPLES_LOG2:0]  err_count_q, err_count_d;
   logic [ACC_W-1:0]       sum_abs_q, sum_abs_d;
   logic [ACC_W:0]         sum_err_q, sum_err_d;
   logic [2*WIDTH-1:0]     max_q, max_d;
   logic [WIDTH-1:0]       worst_a_q, worst_a_d, worst_b_q, worst_b_d;

   logic                   accept, start_ok, pipe_busy;
   logic                   st_valid;
   logic [2*WIDTH:0]       st_d;
   logic [2*WIDTH-1:0]     st_abs;
   logic [WIDTH-1:0]       st_a, st_b;

   assign in_ready = (state_q == ST_RUN) && (cnt_q < NBEATS);
   assign accept   = in_valid && in_ready;
   assign start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

   approx_err_stage #(
      .WIDTH (WIDTH)
   ) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (accept),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_approx (in_approx),
      .pipe_busy (pipe_busy),
      .out_valid (st_valid),
      .out_d     (st_d),
      .out_abs   (st_abs),
      .out_a     (st_a),
      .out_b     (st_b)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_count_d = err_count_q;
      sum_abs_d   = sum_abs_q;
      sum_err_d   = sum_err_q;
      max_d       = max_q;
      worst_a_d   = worst_a_q;
      worst_b_d   = worst_b_q;

      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN;
         ST_RUN:   if (accept && (cnt_q == LAST_BEAT)) state_d = ST_DRAIN;
         ST_DRAIN: if (!pipe_busy) state_d = ST_DONE;
         ST_DONE:  if (start) state_d = ST_RUN;
         default:  state_d = ST_IDLE;
      endcase

      if (accept) cnt_d = cnt_q + CNT_ONE;

      if (st_valid) begin
         if (st_d != '0) err_count_d = err_count_q + CNT_ONE;
         sum_abs_d = sum_abs_q + {{SAMPLES_LOG2{1'b0}}, st_abs};
         sum_err_d = sum_err_q + {{SAMPLES_LOG2{st_d[2*WIDTH]}}, st_d};
         // Strict compare: a tie keeps the operands of the earlier beat.
         if (st_abs > max_q) begin
            max_d     = st_abs;
            worst_a_d = st_a;
            worst_b_d = st_b;
         end
      end

      if (start_ok) begin
         cnt_d       = '0;
         err_count_d = '0;
         sum_abs_d   = '0;
         sum_err_d   = '0;
         max_d       = '0;
         worst_a_d   = '0;
         worst_b_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         err_count_q <= '0;
         sum_abs_q   <= '0;
         sum_err_q   <= '0;
         max_q       <= '0;
         worst_a_q   <= '0;
         worst_b_q   <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         err_count_q <= err_count_d;
         sum_abs_q   <= sum_abs_d;
         sum_err_q   <= sum_err_d;
         max_q       <= max_d;
         worst_a_q   <= worst_a_d;
         worst_b_q   <= worst_b_d;
      end
   end

   assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
   assign done        = (state_q == ST_DONE);
   assign err_count   = err_count_q;
   assign sum_abs_err = sum_abs_q;
   assign sum_err     = sum_err_q;
   assign max_abs_err = max_q;
   assign worst_a     = worst_a_q;
   assign worst_b     = worst_b_q;

endmodule

// File: tb/tb_approx_mul_err_acc.sv
// Scoreboard bench for approx_mul_err_acc with N=4 beats per window.
module tb_approx_mul_err_acc;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned SL    = 2;
   localparam int unsigned ACC_W = 2 * WIDTH + SL;
   localparam int          NB    = 4;

   logic                 clk, rst, start, in_valid, in_ready, busy, done;
   logic [WIDTH-1:0]     in_a, in_b, worst_a, worst_b;
   logic [2*WIDTH-1:0]   in_approx, max_abs_err;
   logic [SL:0]          err_count;
   logic [ACC_W-1:0]     sum_abs_err;
   logic [ACC_W:0]       sum_err;

   approx_mul_err_acc #(
      .WIDTH        (WIDTH),
      .SAMPLES_LOG2 (SL)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_approx   (in_approx),
      .busy        (busy),
      .done        (done),
      .err_count   (err_count),
      .sum_abs_err (sum_abs_err),
      .sum_err     (sum_err),
      .max_abs_err (max_abs_err),
      .worst_a     (worst_a),
      .worst_b     (worst_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      longint ec;
      longint sabs;
      longint serr;
      longint mx;
      longint wa;
      longint wb;
   } stats_t;

   stats_t exp_q[$];
   stats_t m;
   int     m_acc;
   int     checks = 0;
   int     errors = 0;

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, $signed(obs), $signed(exp));
      end
   endtask

   task automatic model_clear();
      m     = '{0, 0, 0, 0, 0, 0};
      m_acc = 0;
   endtask

   task automatic model_beat(input int a, input int b, input int ap);
      longint ex, d, ad;
      ex = longint'(a) * longint'(b);
      d  = ex - longint'(ap);
      ad = (d < 0) ? -d : d;
      if (d != 0) m.ec++;
      m.sabs += ad;
      m.serr += d;
      if (ad > m.mx) begin
         m.mx = ad;
         m.wa = a;
         m.wb = b;
      end
      m_acc++;
      if (m_acc == NB) exp_q.push_back(m);
   endtask

   task automatic drive_beat(input int a, input int b, input int ap, input bit v,
                             output bit acc);
      in_a      = 8'(a);
      in_b      = 8'(b);
      in_approx = 16'(ap);
      in_valid  = v;
      acc       = v && in_ready;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      if (acc) model_beat(a, b, ap);
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   task automatic check_stats_zero(input string tag);
      check_val({tag, "_ec"}, 64'(err_count), 0);
      check_val({tag, "_sabs"}, 64'(sum_abs_err), 0);
      check_val({tag, "_serr"}, 64'(sum_err), 0);
      check_val({tag, "_max"}, 64'(max_abs_err), 0);
      check_val({tag, "_wa"}, 64'(worst_a), 0);
      check_val({tag, "_wb"}, 64'(worst_b), 0);
   endtask

   task automatic compare_pop(input string tag);
      stats_t e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_sb_empty"}, 0, 1);
      end else begin
         e = exp_q.pop_front();
         check_val({tag, "_ec"}, 64'(err_count), 64'(e.ec));
         check_val({tag, "_sabs"}, 64'(sum_abs_err), 64'(e.sabs));
         check_val({tag, "_serr"}, 64'($signed(sum_err)), 64'(e.serr));
         check_val({tag, "_max"}, 64'(max_abs_err), 64'(e.mx));
         check_val({tag, "_wa"}, 64'(worst_a), 64'(e.wa));
         check_val({tag, "_wb"}, 64'(worst_b), 64'(e.wb));
      end
   endtask

   task automatic wait_done(input string tag);
      int cyc;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (!done) check_val({tag, "_timeout"}, 0, 1);
      else compare_pop(tag);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int n, a, b, ap, slots;
      longint ex;

      rst = 1'b1; start = 1'b0; in_valid = 1'b0;
      in_a = '0; in_b = '0; in_approx = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // 1: idle, nothing consumed
      in_valid = 1'b1; in_a = 8'd9; in_b = 8'd9; in_approx = 16'd1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk);
         #1;
         check_val("t1_ready", 64'(in_ready), 0);
         check_val("t1_busy", 64'(busy), 0);
         check_val("t1_done", 64'(done), 0);
      end
      in_valid = 1'b0;
      check_stats_zero("t1");

      // 2: exact beats
      do_start();
      model_clear();
      check_val("t2_busy", 64'(busy), 1);
      for (int i = 0; i < NB; i++) drive_beat(3, 5, 15, 1'b1, acc);
      wait_done("t2");
      check_val("t2_ec_const", 64'(err_count), 0);
      check_val("t2_max_const", 64'(max_abs_err), 0);
      in_valid = 1'b1; in_a = 8'd200; in_b = 8'd200; in_approx = 16'd0;
      repeat (4) @(posedge clk);
      #1;
      in_valid = 1'b0;
      check_val("t2_done_held", 64'(done), 1);
      check_val("t2_no_consume", 64'(sum_abs_err), 0);

      // 3: mixed errors including full-scale
      do_start();
      model_clear();
      check_val("t3_done_clr", 64'(done), 0);
      drive_beat(3, 5, 10, 1'b1, acc);
      drive_beat(3, 5, 20, 1'b1, acc);
      drive_beat(255, 255, 0, 1'b1, acc);
      drive_beat(0, 0, 0, 1'b1, acc);
      wait_done("t3");
      check_val("t3_sabs_const", 64'(sum_abs_err), 65035);
      check_val("t3_serr_const", 64'($signed(sum_err)), 65025);
      check_val("t3_wa_const", 64'(worst_a), 255);

      // 4: tie on max keeps first operands
      do_start();
      model_clear();
      drive_beat(1, 7, 0, 1'b1, acc);
      drive_beat(7, 1, 14, 1'b1, acc);
      drive_beat(2, 3, 6, 1'b1, acc);
      drive_beat(0, 9, 0, 1'b1, acc);
      wait_done("t4");
      check_val("t4_wa_const", 64'(worst_a), 1);
      check_val("t4_wb_const", 64'(worst_b), 7);

      // 5: alternating valid, latency to done
      do_start();
      model_clear();
      n = 0; slots = 0;
      while (n < NB && slots < 16) begin
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         ex = longint'(a) * longint'(b);
         ap = int'(ex) + int'($urandom_range(0, 6)) - 3;
         if (ap < 0) ap = 0;
         if (ap > 65535) ap = 65535;
         drive_beat(a, b, ap, (slots % 2) == 0, acc);
         if (acc) n++;
         slots++;
      end
      check_val("t5_accepts", 64'(n), NB);
      check_val("t5_ready_low", 64'(in_ready), 0);
      in_valid = 1'b1;
      n = 0;
      while (!done && n < 10) begin
         @(posedge clk);
         #1;
         n++;
      end
      in_valid = 1'b0;
      check_val("t5_done_lat", 64'(n), 3);
      compare_pop("t5");

      // 6a: start during RUN is ignored
      do_start();
      model_clear();
      drive_beat(10, 10, 90, 1'b1, acc);
      drive_beat(4, 4, 20, 1'b1, acc);
      do_start();
      check_val("t6_busy_after_start", 64'(busy), 1);
      drive_beat(6, 6, 36, 1'b1, acc);
      drive_beat(12, 3, 30, 1'b1, acc);
      wait_done("t6a");

      // 6b: reset aborts an open window
      do_start();
      model_clear();
      drive_beat(200, 200, 0, 1'b1, acc);
      drive_beat(100, 100, 5, 1'b1, acc);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("t6_busy", 64'(busy), 0);
      check_val("t6_ready", 64'(in_ready), 0);
      check_val("t6_done", 64'(done), 0);
      check_stats_zero("t6_rst");
      repeat (6) @(posedge clk);
      #1;
      check_val("t6_done_late", 64'(done), 0);
      check_val("t6_sabs_late", 64'(sum_abs_err), 0);

      // random window with random bubbles
      do_start();
      model_clear();
      n = 0; slots = 0;
      while (n < NB && slots < 40) begin
         a  = int'($urandom_range(0, 255));
         b  = int'($urandom_range(0, 255));
         ap = int'($urandom_range(0, 65535));
         drive_beat(a, b, ap, bit'($urandom_range(0, 1)), acc);
         if (acc) n++;
         slots++;
      end
      wait_done("trand");
      check_val("sb_drained", 64'(exp_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
